// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for the multi-cycle RV32I core. Sequences a shared datapath
//   (one ALU, one unified memory port, IR/OldPC/A/B/ALUOut registers) by
//   issuing per-state mux selects and write enables. Memory states hold until
//   mem_ready; a watchdog aborts accesses that never complete.
//
//   State table:
//     state     | meaning
//     FETCH     | read instruction at PC, PC <= PC+4, load IR/OldPC
//     DECODE    | decode opcode, ALUOut <= OldPC + imm (branch/jump target)
//     MEMADR    | ALUOut <= rs1 + imm (load/store address)
//     MEMREAD   | read data memory at ALUOut
//     MEMWB     | write loaded data to rd
//     MEMWRITE  | write rs2 to memory at ALUOut
//     EXECUTER  | ALUOut <= rs1 op rs2
//     EXECUTEI  | ALUOut <= rs1 op imm
//     ALUWB     | write ALUOut to rd
//     BEQ       | compare rs1/rs2, PC <= target when equal
//     JAL       | ALUOut <= OldPC+4, PC <= target
//     TRAP      | unsupported opcode, no architectural writes
//
//   Ports:
//     clk, rst_n                   clock, async active-low reset
//     opcode, funct3, funct7_5     instruction fields from IR
//     zero                         ALU zero flag (current cycle)
//     mem_ready                    memory completes request this cycle
//     mem_req, MemWrite, AdrSrc    memory port control
//     IRWrite, PCWrite, RegWrite   register write enables
//     ResultSrc, ALUSrcA, ALUSrcB  datapath mux selects
//     ImmSrc, ALUControl           immediate format, ALU operation
//     instr_done, illegal_instr,
//     mem_timeout                  one-cycle status pulses
//     state                        current state (debug)
//
//   Outputs are Mealy: FETCH/MEMREAD/MEMWRITE enables depend on mem_ready and
//   BEQ's PCWrite on zero within the same cycle.

module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic          mem_state;
    logic          abort;
    logic [2:0]    alu_funct;

    // Counter holds the number of wait cycles already spent; the current
    // waiting cycle is the one that makes it reach MEM_TIMEOUT.
    assign mem_state = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
    assign abort     = mem_state && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign state     = cur;

    always_comb begin
        alu_funct = 3'b000;
        case (funct3)
            3'b000:  alu_funct = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:    if (mem_ready) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: nxt = S_MEMADR;
                    7'b0110011:             nxt = S_EXECUTER;
                    7'b0010011:             nxt = S_EXECUTEI;
                    7'b1100011:             nxt = S_BEQ;
                    7'b1101111:             nxt = S_JAL;
                    default:                nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) nxt = S_MEMWB;
            S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: nxt = (cur == S_JAL || cur == S_EXECUTER || cur == S_EXECUTEI) ? S_ALUWB : S_FETCH;
            default:    nxt = S_FETCH;
        endcase
        if (abort) nxt = S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            // Only a genuine hold (waiting, not aborting) keeps counting.
            if (mem_state && !mem_ready && !abort) wait_cnt <= wait_cnt + 1'b1;
            else                                   wait_cnt <= '0;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = 3'b000;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = abort;
        case (opcode)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                AdrSrc     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                instr_done    = 1'b1;
            end
            default: ;
        endcase
        // Reset forces every enable, pulse and select low even though the
        // state register already reads FETCH.
        if (!rst_n) begin
            mem_req       = 1'b0;
            MemWrite      = 1'b0;
            AdrSrc        = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            ResultSrc     = 2'b00;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ImmSrc        = 2'b00;
            ALUControl    = 3'b000;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
            mem_timeout   = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control FSM for the multi-cycle RV32I core. It sequences a shared datapath: one ALU, one unified instruction/data memory port, and the IR, OldPC, A/B and ALUOut registers. It issues per-state mux selects and write enables, and holds in memory states until memory acknowledges. A watchdog aborts memory accesses that never complete.

Parameters:
MEM_TIMEOUT, 16, max wait cycles in a memory state before abort (>=1)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes request this cycle
mem_req  out  1  memory request valid
MemWrite  out  1  store strobe, valid with mem_req
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC
RegWrite  out  1  register file write
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 reg
ALUSrcB  out  2  00=rs2 reg, 01=Imm, 10=const 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J (pure function of opcode)
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
instr_done  out  1  one-cycle pulse on final cycle of each instruction
illegal_instr  out  1  one-cycle pulse in TRAP
mem_timeout  out  1  one-cycle pulse on watchdog abort
state  out  4  current state, debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset: state -> FETCH asynchronously; wait counter -> 0. While rst_n=0, all enables and pulses are 0 and all selects are 0. The first post-reset cycle is FETCH.
- Unlisted outputs are 0 in each state.
- FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold with no write enables.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: mem_req, AdrSrc=1, ResultSrc=00. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite, instr_done. Go to FETCH.
- MEMWRITE: mem_req, MemWrite, AdrSrc=1, ResultSrc=00. On mem_ready: instr_done, go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, funct decode. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, funct decode. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite, instr_done. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero, instr_done. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
- TRAP: illegal_instr, instr_done. Go to FETCH; no architectural writes.
- Funct decode (R/I states):
  - funct3=000: sub if opcode[5]&funct7_5, else add
  - funct3=010: slt
  - funct3=110: or
  - funct3=111: and
  - other funct3: add
- Watchdog: counter increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0, and clears on state change. When the count reaches MEM_TIMEOUT with mem_ready still 0, that cycle pulses mem_timeout and the FSM goes to FETCH. The abort suppresses IRWrite, PCWrite and RegWrite, and the PC is not advanced. mem_ready on the same cycle wins over timeout.
- Latencies at zero wait: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4, illegal 3.

Test Plan:
- Reset mid-MEMREAD (rst_n low for 1 cycle) -> state=0 immediately, all enables 0; after release FETCH with mem_req=1.
- R-type sub (opcode 0110011, funct3 000, funct7_5=1), mem_ready=1 -> states 0,1,6,8; ALUControl=001 in EXECUTER; RegWrite and instr_done in cycle 4 only.
- lw with mem_ready low 3 cycles in MEMREAD -> state holds at 3 with mem_req=1 for 4 cycles; then MEMWB with ResultSrc=01, RegWrite=1.
- beq, zero=1 then zero=0 -> PCWrite=1 / PCWrite=0 in BEQ; ALUControl=001; 3 cycles each.
- jal -> PCWrite=1 in JAL with ALUSrcB=10; then ALUWB with RegWrite=1.
- Opcode 1110011 -> TRAP: illegal_instr pulse, no RegWrite/MemWrite. Separately, mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> mem_timeout pulse on 4th wait cycle, IRWrite never asserted.
